bitrev_stream_sink: RTL and testbench
=====================================

// Module: bitrev_stream_sink
// PURPOSE
//   Streaming consumer and checker for the output side of the bit-reversal core.
//   - Accepts frames of N = 2**K samples over a valid/ready handshake and applies
//     programmable back-pressure.
//   - Checks each sample against the expected reordered index and keeps frame,
//     error and first-error status for the bring-up and debug register block.
//   - Sits downstream of the bit-reversal core in place of the FFT datapath.
// PARAMETERS
//   K          10        log2 of frame length; N = 1<<K samples per frame
//   DW         32        sample data width; DW >= K
//   LFSR_SEED  16'hACE1  reset value of the stall LFSR; must be nonzero
// PORTS
//   clk_i              in   1    clock; all logic on rising edge
//   rst_i              in   1    reset, synchronous, active-high
//   enable_i           in   1    start or continue consuming frames
//   mode_i             in   1    0: expect rev(idx); 1: expect idx (natural order)
//   stall_en_i         in   1    1: enable pseudo-random ready throttling
//   clr_i              in   1    synchronous clear of status counters and capture
//   valid_i            in   1    upstream sample valid
//   data_i             in   DW   upstream sample
//   ready_o            out  1    sink ready
//   busy_o             out  1    1 while state != IDLE
//   frame_done_o       out  1    one-cycle pulse at end of each frame
//   frame_cnt_o        out  16   completed frames; wraps modulo 2**16
//   err_cnt_o          out  16   mismatching samples; saturates at 16'hFFFF
//   first_err_vld_o    out  1    sticky: first-error capture valid
//   first_err_idx_o    out  K    index of the first mismatch
//   first_err_data_o   out  DW   data_i value seen at the first mismatch
// BEHAVIOUR
//   Reset: all outputs 0 (ready_o=0, busy_o=0); state=IDLE; idx=0; lfsr=LFSR_SEED.
//     rst_i has priority over every other input. Mid-frame reset abandons the frame.
//   FSM states:
//     IDLE: ready_o=0. If enable_i=1, go to RUN; idx<=0; latch mode_i into mode_q.
//     RUN: accepts samples. A transfer occurs when valid_i & ready_o.
//       Each transfer increments idx. A transfer at idx==N-1 goes to DONE.
//     DONE: one cycle. ready_o=0; frame_done_o=1; frame_cnt++.
//       Next state is RUN (idx<=0, relatch mode_i) if enable_i=1, else IDLE.
//   enable_i=0 during RUN does not abort; the frame runs to completion.
//   mode_i is sampled only at frame start. Changes mid-frame are ignored.
//   ready_o = (state==RUN) & ~(stall_en_i & lfsr[1] & lfsr[0]).
//     This stalls about 25% of cycles when stall_en_i=1.
//     ready_o depends only on registers and stall_en_i, never on valid_i.
//   LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
//     Advances every cycle while state==RUN; holds otherwise.
//   Expected value: exp = {(DW-K)'b0, mode_q ? idx : rev(idx)}.
//     rev(x)[i] = x[K-1-i]. The upper DW-K bits of data_i must be zero.
//   Mismatch on a transfer (data_i !== exp):
//     - err_cnt++ with saturation at 16'hFFFF.
//     - If first_err_vld_o=0: capture idx and data_i, set first_err_vld_o.
//   Status outputs update on the clock edge that completes the transfer (latency 1).
//   clr_i=1 zeroes frame_cnt, err_cnt and the first-error capture.
//     It does not affect the FSM, idx or the LFSR.
//     If clr_i coincides with an increment or capture, the clear wins.
//   Back-to-back operation: with valid_i=1 and stall off, a frame takes N RUN cycles
//     plus 1 DONE cycle.
//   valid_i held while ready_o=0 is legal; the source keeps data_i stable.
// TESTING
//   1 Reset: rst_i=1 for 4 cycles with valid_i=1
//     -> ready_o=0, busy_o=0, all counters and capture 0.
//   2 mode 0, stall off, continuous valid, data=rev(i) for i=0..1023
//     -> 1024 transfers in 1024 cycles, one frame_done_o pulse, frame_cnt=1, err_cnt=0.
//   3 Same as 2, but idx 5 carries rev(5)^1 and idx 9 carries 0
//     -> err_cnt=2, first_err_idx=5, first_err_data=rev(5)^1.
//   4 stall_en=1, mode 1, data=i
//     -> ready_o low on a nonzero number of cycles (fewer than 50%), all 1024 accepted,
//        err_cnt=0.
//   5 enable_i dropped at idx 500
//     -> frame completes, frame_cnt=1, state returns to IDLE, ready_o stays 0.
//   6 rst_i at idx 300, then a clean frame; clr_i pulsed together with an error
//     -> counters restart from 0 and the next frame checks from idx 0; clr_i wins
//        over the concurrent increment.

Source files
------------

// File: rtl/bitrev_stream_sink.sv
// bitrev_stream_sink: frame consumer and checker placed downstream of the
// bit-reversal core. Accepts N = 2**K samples per frame, optionally throttles
// ready with an LFSR, and keeps frame/error/first-error status.
module bitrev_stream_sink #(
  parameter int          K         = 10,
  parameter int          DW        = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          mode_i,
  input  logic          stall_en_i,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [15:0]   frame_cnt_o,
  output logic [15:0]   err_cnt_o,
  output logic          first_err_vld_o,
  output logic [K-1:0]  first_err_idx_o,
  output logic [DW-1:0] first_err_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [K-1:0]    idx_q, idx_d;
  logic            mode_q, mode_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            fe_vld_q, fe_vld_d;
  logic [K-1:0]    fe_idx_q, fe_idx_d;
  logic [DW-1:0]   fe_data_q, fe_data_d;

  logic [K-1:0]    rev_idx;
  logic [DW-1:0]   exp_data;
  logic            ready_w;
  logic            xfer;
  logic            mismatch;

  // Expected sample: bit-reversed or natural index, zero-extended to DW
  always_comb begin
    rev_idx = '0;
    for (int unsigned i = 0; i < K; i++) begin
      rev_idx[i] = idx_q[K-1-i];
    end
    exp_data = '0;
    exp_data[K-1:0] = mode_q ? idx_q : rev_idx;
  end

  assign ready_w  = (state_q == S_RUN) & ~(stall_en_i & lfsr_q[1] & lfsr_q[0]);
  assign xfer     = valid_i & ready_w;
  assign mismatch = xfer & (data_i != exp_data);

  // Next-state logic for FSM, index, LFSR and status
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    fe_vld_d    = fe_vld_q;
    fe_idx_d    = fe_idx_q;
    fe_data_d   = fe_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_RUN;
          idx_d   = '0;
          mode_d  = mode_i;
        end
      end
      S_RUN: begin
        if (xfer) begin
          idx_d = idx_q + {{(K-1){1'b0}}, 1'b1};
          if (idx_q == '1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (enable_i) begin
          state_d = S_RUN;
          idx_d   = '0;
          mode_d  = mode_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Galois form, x^16+x^14+x^13+x^11+1
    if (state_q == S_RUN) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
      if (!fe_vld_q) begin
        fe_vld_d  = 1'b1;
        fe_idx_d  = idx_q;
        fe_data_d = data_i;
      end
    end

    // Clear overrides any same-cycle increment or capture
    if (clr_i) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      fe_vld_d    = 1'b0;
      fe_idx_d    = '0;
      fe_data_d   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      fe_vld_q    <= 1'b0;
      fe_idx_q    <= '0;
      fe_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      fe_vld_q    <= fe_vld_d;
      fe_idx_q    <= fe_idx_d;
      fe_data_q   <= fe_data_d;
    end
  end

  assign ready_o          = ready_w;
  assign busy_o           = (state_q != S_IDLE);
  assign frame_done_o     = (state_q == S_DONE);
  assign frame_cnt_o      = frame_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_vld_o  = fe_vld_q;
  assign first_err_idx_o  = fe_idx_q;
  assign first_err_data_o = fe_data_q;

endmodule

// File: tb/tb_bitrev_stream_sink.sv
// Directed bench for bitrev_stream_sink (K=10, DW=32).
module tb_bitrev_stream_sink;

  localparam int K  = 10;
  localparam int DW = 32;
  localparam int N  = 1 << K;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, enable_i = 1'b0, mode_i = 1'b0, stall_en_i = 1'b0;
  logic          clr_i = 1'b0, valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, busy_o, frame_done_o, first_err_vld_o;
  logic [15:0]   frame_cnt_o, err_cnt_o;
  logic [K-1:0]  first_err_idx_o;
  logic [DW-1:0] first_err_data_o;

  int total = 0;
  int bad   = 0;

  bitrev_stream_sink #(.K(K), .DW(DW), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .stall_en_i(stall_en_i), .clr_i(clr_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o),
    .first_err_vld_o(first_err_vld_o), .first_err_idx_o(first_err_idx_o),
    .first_err_data_o(first_err_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rev10(input int x);
    logic [DW-1:0] r;
    logic [31:0]   v;
    v = 32'(x);
    r = '0;
    for (int b = 0; b < K; b++) r[b] = v[K-1-b];
    return r;
  endfunction

  // Sample for index i; inj=1 corrupts idx 5 (rev(5)^1 = 0x281) and idx 9 (0)
  function automatic logic [DW-1:0] gen(input int i, input logic mode, input logic inj);
    if (inj && i == 5) return 32'h281;
    if (inj && i == 9) return '0;
    return mode ? 32'(i) : rev10(i);
  endfunction

  // Streams one frame with valid held high; drive on negedge, DUT samples on posedge.
  // drop_at/rst_at/clr_at/flip_at = -1 disables that event.
  task automatic run_frame(input logic mode, input logic inj, input logic stall,
                           input int drop_at, input int rst_at, input int clr_at,
                           input int flip_at,
                           output int xfers, output int stalls, output int run_cyc,
                           output int dones);
    int  i;
    bit  finished;
    i = 0; xfers = 0; stalls = 0; run_cyc = 0; dones = 0; finished = 0;
    @(negedge clk);
    mode_i = mode; stall_en_i = stall; enable_i = 1'b1; valid_i = 1'b1;
    data_i = gen(0, mode, inj);
    for (int c = 0; c < 4000 && !finished; c++) begin
      @(negedge clk);
      if (frame_done_o) begin
        dones++;
        enable_i = 1'b0; valid_i = 1'b0;
        finished = 1;
      end else if (rst_at >= 0 && i == rst_at) begin
        rst_i = 1'b1; valid_i = 1'b0; enable_i = 1'b0;
        finished = 1;
      end else begin
        if (busy_o) run_cyc++;
        if (busy_o && !ready_o) stalls++;
        if (ready_o) begin
          if (i == clr_at) clr_i = 1'b1;
          @(posedge clk);
          #1;
          clr_i = 1'b0;
          xfers++;
          i++;
          if (i == drop_at) enable_i = 1'b0;
          if (i == flip_at) mode_i = ~mode;
          data_i = gen(i, mode, inj);
        end
      end
    end
    if (!finished) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  int xf, st, rc, dn;

  initial begin
    // 1: reset held 4 cycles with valid asserted
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b1; data_i = 32'h3FF;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("rst_fe_vld", 32'(first_err_vld_o), 32'd0);
    chk("rst_fe_data", first_err_data_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0; valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(ready_o), 32'd0);

    // 2: clean frame, mode 0, no stall
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, -1, -1, xf, st, rc, dn);
    chk("t2_xfers", 32'(xf), 32'd1024);
    chk("t2_run_cycles", 32'(rc), 32'd1024);
    chk("t2_dones", 32'(dn), 32'd1);
    @(posedge clk); #1;
    chk("t2_frame_cnt", 32'(frame_cnt_o), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("t2_fe_vld", 32'(first_err_vld_o), 32'd0);
    chk("t2_done_pulse_low", 32'(frame_done_o), 32'd0);
    chk("t2_busy_idle", 32'(busy_o), 32'd0);

    // 3: errors at idx 5 and 9
    run_frame(1'b0, 1'b1, 1'b0, -1, -1, -1, -1, xf, st, rc, dn);
    @(posedge clk); #1;
    chk("t3_err_cnt", 32'(err_cnt_o), 32'd2);
    chk("t3_fe_vld", 32'(first_err_vld_o), 32'd1);
    chk("t3_fe_idx", 32'(first_err_idx_o), 32'd5);
    chk("t3_fe_data", first_err_data_o, 32'h281);
    chk("t3_frame_cnt", 32'(frame_cnt_o), 32'd2);

    // 4: stall on, mode 1; mode_i flipped mid-frame must be ignored
    run_frame(1'b1, 1'b0, 1'b1, -1, -1, -1, 100, xf, st, rc, dn);
    stall_en_i = 1'b0;
    chk("t4_xfers", 32'(xf), 32'd1024);
    chk("t4_stalls_nonzero", 32'(st > 0), 32'd1);
    chk("t4_stalls_under_half", 32'(st * 2 < rc), 32'd1);
    chk("t4_run_cycles", 32'(rc), 32'(1024 + st));
    @(posedge clk); #1;
    chk("t4_err_cnt", 32'(err_cnt_o), 32'd2);
    chk("t4_fe_idx_kept", 32'(first_err_idx_o), 32'd5);
    chk("t4_frame_cnt", 32'(frame_cnt_o), 32'd3);

    // 5: enable dropped at idx 500; frame still completes
    run_frame(1'b0, 1'b0, 1'b0, 500, -1, -1, -1, xf, st, rc, dn);
    chk("t5_xfers", 32'(xf), 32'd1024);
    chk("t5_dones", 32'(dn), 32'd1);
    @(posedge clk); #1;
    chk("t5_frame_cnt", 32'(frame_cnt_o), 32'd4);
    chk("t5_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_ready_low", 32'(ready_o), 32'd0);

    // 6a: reset mid-frame at idx 300
    run_frame(1'b0, 1'b0, 1'b0, -1, 300, -1, -1, xf, st, rc, dn);
    chk("t6_xfers_before_rst", 32'(xf), 32'd300);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    chk("t6_rst_err_cnt", 32'(err_cnt_o), 32'd0);
    // 6b: clean frame must check from idx 0
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, -1, -1, xf, st, rc, dn);
    @(posedge clk); #1;
    chk("t6_clean_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("t6_clean_frame_cnt", 32'(frame_cnt_o), 32'd1);
    // 6c: clr_i on the idx 9 error transfer wipes both errors and frame count
    run_frame(1'b0, 1'b1, 1'b0, -1, -1, 9, -1, xf, st, rc, dn);
    @(posedge clk); #1;
    chk("t6_clr_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("t6_clr_fe_vld", 32'(first_err_vld_o), 32'd0);
    chk("t6_clr_frame_cnt", 32'(frame_cnt_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
